// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: 32-bit multicycle RISC core, FETCH/DECODE/EXEC/[MEM]/WB per instruction
//   clock, reset                    : system clock, asynchronous active-low reset
//   address_imem, q_imem            : synchronous word-addressed instruction ROM
//   ctrl_writeEnable/WriteReg/readRegA/readRegB, data_writeReg, data_readRegA/B : external regfile
//   wren, address_dmem, data, q_dmem: synchronous word-addressed data RAM
module multicycle_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, st_q, st_d, npc_q, npc_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [4:0]  op, rd, rs, rt, shamt, aluop, rega_idx, regb_idx, ex_wreg;
    logic [31:0] imm, tgt, pc1, sum, diff, addi_sum, ex_res, ex_npc;
    logic        ex_we, add_ovf, sub_ovf, addi_ovf, is_lw, is_sw;

    assign op       = ir_q[31:27];
    assign rd       = ir_q[26:22];
    assign rs       = ir_q[21:17];
    assign rt       = ir_q[16:12];
    assign shamt    = ir_q[11:7];
    assign aluop    = ir_q[6:2];
    assign imm      = {{15{ir_q[16]}}, ir_q[16:0]};
    assign tgt      = {5'd0, ir_q[26:0]};
    assign pc1      = pc_q + 32'd1;
    assign is_lw    = op == OP_LW;
    assign is_sw    = op == OP_SW;
    assign rega_idx = (op == OP_BNE || op == OP_BLT || op == OP_JR) ? rd : op == OP_BEX ? 5'd30 : rs;
    assign regb_idx = is_sw ? rd : (op == OP_BNE || op == OP_BLT) ? rs : rt;
    assign sum      = data_readRegA + data_readRegB;
    assign diff     = data_readRegA - data_readRegB;
    assign addi_sum = data_readRegA + imm;
    // Signed overflow: operands agree in sign (differ for sub) but the result sign does not.
    assign add_ovf  = data_readRegA[31] == data_readRegB[31] && sum[31] != data_readRegA[31];
    assign sub_ovf  = data_readRegA[31] != data_readRegB[31] && diff[31] != data_readRegA[31];
    assign addi_ovf = data_readRegA[31] == imm[31] && addi_sum[31] != data_readRegA[31];

    // Execute: result, destination and next PC; overflow redirects the write to r30.
    always_comb begin
        ex_we   = 1'b0;
        ex_wreg = rd;
        ex_res  = 32'd0;
        ex_npc  = pc1;
        case (op)
            OP_R: begin
                ex_we   = aluop <= 5'd5;
                ex_wreg = ((aluop == 5'd0 && add_ovf) || (aluop == 5'd1 && sub_ovf)) ? 5'd30 : rd;
                case (aluop)
                    5'd0:    ex_res = add_ovf ? 32'd1 : sum;
                    5'd1:    ex_res = sub_ovf ? 32'd3 : diff;
                    5'd2:    ex_res = data_readRegA & data_readRegB;
                    5'd3:    ex_res = data_readRegA | data_readRegB;
                    5'd4:    ex_res = data_readRegA << shamt;
                    5'd5:    ex_res = $signed(data_readRegA) >>> shamt;
                    default: ex_res = 32'd0;
                endcase
            end
            OP_ADDI: begin
                ex_we   = 1'b1;
                ex_wreg = addi_ovf ? 5'd30 : rd;
                ex_res  = addi_ovf ? 32'd2 : addi_sum;
            end
            OP_LW, OP_SW: begin
                ex_we  = is_lw;
                ex_res = addi_sum;
            end
            OP_BNE: ex_npc = data_readRegA != data_readRegB ? pc1 + imm : pc1;
            OP_BLT: ex_npc = $signed(data_readRegA) < $signed(data_readRegB) ? pc1 + imm : pc1;
            OP_J:   ex_npc = tgt;
            OP_JAL: begin
                ex_we   = 1'b1;
                ex_wreg = 5'd31;
                ex_res  = pc1;
                ex_npc  = tgt;
            end
            OP_JR:  ex_npc = data_readRegA;
            OP_BEX: ex_npc = data_readRegA != 32'd0 ? tgt : pc1;
            OP_SETX: begin
                ex_we   = 1'b1;
                ex_wreg = 5'd30;
                ex_res  = tgt;
            end
            default: ex_npc = pc1;
        endcase
    end

    always_comb begin
        pc_d   = state_q == WB ? npc_q : pc_q;
        ir_d   = state_q == DECODE ? q_imem : ir_q;
        res_d  = state_q == EXEC ? ex_res : res_q;
        st_d   = state_q == EXEC ? data_readRegB : st_q;
        npc_d  = state_q == EXEC ? ex_npc : npc_q;
        we_d   = state_q == EXEC ? ex_we : we_q;
        wreg_d = state_q == EXEC ? ex_wreg : wreg_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            ir_q   <= 32'd0;
            res_q  <= 32'd0;
            st_q   <= 32'd0;
            npc_q  <= 32'd0;
            we_q   <= 1'b0;
            wreg_q <= 5'd0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            res_q  <= res_d;
            st_q   <= st_d;
            npc_q  <= npc_d;
            we_q   <= we_d;
            wreg_q <= wreg_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
            MEM:     state_d = WB;
            default: state_d = FETCH;
        endcase
    end

    // Writes exist only as WB/MEM pulses, so a reset before them drops the instruction.
    always_comb begin
        address_imem     = pc_q;
        ctrl_readRegA    = state_q == EXEC ? rega_idx : 5'd0;
        ctrl_readRegB    = state_q == EXEC ? regb_idx : 5'd0;
        wren             = state_q == MEM && is_sw;
        address_dmem     = state_q == MEM ? res_q : 32'd0;
        data             = state_q == MEM ? st_q : 32'd0;
        ctrl_writeEnable = state_q == WB && we_q && wreg_q != 5'd0;
        ctrl_writeReg    = state_q == WB ? wreg_q : 5'd0;
        data_writeReg    = state_q == WB ? (is_lw ? q_dmem : res_q) : 32'd0;
    end
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core: ISA-level reference model against the core with ROM, RAM and regfile
module tb_multicycle_cpu_core;
    localparam logic [4:0] OP_R = 5'd0, OP_J = 5'd1, OP_BNE = 5'd2, OP_JAL = 5'd3, OP_JR = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5, OP_BLT = 5'd6, OP_SW = 5'd7, OP_LW = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21, OP_BEX = 5'd22;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_imem, q_imem, data_writeReg, data_readRegA, data_readRegB;
    logic [31:0] address_dmem, data, q_dmem;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic        ctrl_writeEnable, wren;

    logic [31:0] rom [4096];
    logic [31:0] ram [4096] = '{default: '0};
    logic [31:0] rf [32] = '{default: '0};
    logic [31:0] m_mem [4096] = '{default: '0};
    logic [31:0] m_reg [32] = '{default: '0};
    logic [31:0] m_pc = 32'd0;
    int errors = 0;
    int checks = 0;

    multicycle_cpu_core #(.RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_imem <= rom[address_imem[11:0]];
    always @(posedge clock) begin
        q_dmem <= ram[address_dmem[11:0]];
        if (wren) ram[address_dmem[11:0]] <= data;
    end
    always @(posedge clock) if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
    assign data_readRegA = ctrl_readRegA == 5'd0 ? 32'd0 : rf[ctrl_readRegA];
    assign data_readRegB = ctrl_readRegB == 5'd0 ? 32'd0 : rf[ctrl_readRegB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh, input logic [4:0] alu);
        return {OP_R, rd, rs, rt, sh, alu, 2'b00};
    endfunction

    function automatic logic [31:0] jt(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0]  ops [14];
        logic [31:0] w;
        int          sel;
        ops = '{OP_R, OP_R, OP_R, OP_ADDI, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_J, OP_JAL, OP_JR, OP_BEX, OP_SETX};
        w   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 14) w[31:27] = ops[sel];
        if (w[31:27] == OP_R) w[6:2] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // Execute one instruction in the ISA model and watch the core's bus activity for it.
    task automatic step();
        logic [31:0] ins, a, b, c, imm, t, npc, ewd, ema, emd, addr, g_wd, g_ma, g_md;
        logic [4:0]  op, rd, rs, rt, sh, alu, ewr, g_wr;
        logic        ewe, emw;
        longint      s;
        int          lat, n_we, n_mw;
        ins = rom[m_pc[11:0]];
        {op, rd, rs, rt, sh, alu} = ins[31:2];
        a = m_reg[rs];
        b = m_reg[rt];
        c = m_reg[rd];
        imm = {{15{ins[16]}}, ins[16:0]};
        t = {5'd0, ins[26:0]};
        ewe = 1'b0; ewr = rd; ewd = 32'd0; emw = 1'b0; ema = 32'd0; emd = 32'd0;
        lat = 4;
        npc = m_pc + 32'd1;
        case (op)
            OP_R: begin
                ewe = alu <= 5'd5;
                case (alu)
                    5'd0: begin
                        s = longint'($signed(a)) + longint'($signed(b));
                        ewd = s[31:0];
                        if (s > S_MAX || s < S_MIN) begin ewr = 5'd30; ewd = 32'd1; end
                    end
                    5'd1: begin
                        s = longint'($signed(a)) - longint'($signed(b));
                        ewd = s[31:0];
                        if (s > S_MAX || s < S_MIN) begin ewr = 5'd30; ewd = 32'd3; end
                    end
                    5'd2: ewd = a & b;
                    5'd3: ewd = a | b;
                    5'd4: ewd = a << sh;
                    5'd5: ewd = $signed(a) >>> sh;
                    default: ewd = 32'd0;
                endcase
            end
            OP_ADDI: begin
                s = longint'($signed(a)) + longint'($signed(imm));
                ewe = 1'b1;
                ewd = s[31:0];
                if (s > S_MAX || s < S_MIN) begin ewr = 5'd30; ewd = 32'd2; end
            end
            OP_LW: begin
                addr = a + imm;
                ewe = 1'b1;
                ewd = m_mem[addr[11:0]];
                lat = 5;
            end
            OP_SW: begin
                emw = 1'b1;
                ema = a + imm;
                emd = c;
                lat = 5;
            end
            OP_BNE:  if (c != a) npc = m_pc + 32'd1 + imm;
            OP_BLT:  if ($signed(c) < $signed(a)) npc = m_pc + 32'd1 + imm;
            OP_J:    npc = t;
            OP_JAL:  begin ewe = 1'b1; ewr = 5'd31; ewd = m_pc + 32'd1; npc = t; end
            OP_JR:   npc = c;
            OP_BEX:  if (m_reg[30] != 32'd0) npc = t;
            OP_SETX: begin ewe = 1'b1; ewr = 5'd30; ewd = t; end
            default: npc = m_pc + 32'd1;
        endcase
        if (ewr == 5'd0) ewe = 1'b0;
        n_we = 0; n_mw = 0; g_wr = 5'd0; g_wd = 32'd0; g_ma = 32'd0; g_md = 32'd0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            if (k == 1) check("fetch_pc", address_imem, m_pc);
            if (ctrl_writeEnable) begin
                n_we += (k == lat) ? 1 : 100;
                g_wr = ctrl_writeReg;
                g_wd = data_writeReg;
            end
            if (wren) begin
                n_mw += (k == 4) ? 1 : 100;
                g_ma = address_dmem;
                g_md = data;
            end
        end
        check("we_pulses", n_we, {31'd0, ewe});
        check("wren_pulses", n_mw, {31'd0, emw});
        if (ewe) begin
            check("wr_reg", {27'd0, g_wr}, {27'd0, ewr});
            check("wr_data", g_wd, ewd);
        end
        if (emw) begin
            check("mem_addr", g_ma, ema);
            check("mem_data", g_md, emd);
        end
        if (ewe) m_reg[ewr] = ewd;
        if (emw) m_mem[ema[11:0]] = emd;
        m_pc = npc;
    endtask

    // Run n instructions, then move past the final regfile write edge.
    task automatic run(input int n);
        repeat (n) step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_pc", address_imem, 32'd0);
        check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check("rst_wren", {31'd0, wren}, 32'd0);
        check("rst_dmem", address_dmem, 32'd0);
        check("rst_wdata", data_writeReg, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        m_pc = 32'd0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        rom[0] = ri(OP_ADDI, 5'd1, 5'd0, 17'd5);
        rom[1] = ri(OP_ADDI, 5'd2, 5'd0, 17'h1FFFD);
        rom[2] = rr(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
        do_reset();
        run(3);
        check("t1_r1", rf[1], 32'd5);
        check("t1_r2", rf[2], 32'hFFFFFFFD);
        check("t1_r3", rf[3], 32'd2);

        clear_rom();
        rom[1] = rr(5'd3, 5'd1, 5'd1, 5'd0, 5'd0);
        do_reset();
        run(1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 check("abort_pc", address_imem, 32'd0);
        repeat (2) begin
            @(negedge clock);
            check("abort_we", {31'd0, ctrl_writeEnable}, 32'd0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        m_pc = 32'd0;
        check("abort_r3", rf[3], 32'd2);
        run(2);
        check("rerun_r3", rf[3], 32'd10);

        clear_rom();
        rom[0] = ri(OP_ADDI, 5'd1, 5'd0, 17'h0FFFF);
        rom[1] = rr(5'd2, 5'd1, 5'd0, 5'd15, 5'd4);
        rom[2] = rr(5'd3, 5'd2, 5'd2, 5'd0, 5'd0);
        rom[3] = ri(OP_ADDI, 5'd4, 5'd2, 17'h0FFFF);
        rom[4] = ri(OP_ADDI, 5'd8, 5'd0, 17'd1);
        rom[5] = rr(5'd8, 5'd8, 5'd0, 5'd31, 5'd4);
        rom[6] = rr(5'd7, 5'd8, 5'd2, 5'd0, 5'd1);
        do_reset();
        run(3);
        check("ovf_r2", rf[2], 32'h7FFF8000);
        check("ovf_add_r30", rf[30], 32'd1);
        check("ovf_add_r3", rf[3], 32'd10);
        run(1);
        check("ovf_addi_r30", rf[30], 32'd2);
        check("ovf_addi_r4", rf[4], 32'd0);
        run(3);
        check("ovf_r8", rf[8], 32'h80000000);
        check("ovf_sub_r30", rf[30], 32'd3);
        check("ovf_sub_r7", rf[7], 32'd0);

        clear_rom();
        rom[0] = ri(OP_ADDI, 5'd1, 5'd0, 17'd7);
        rom[1] = ri(OP_SW, 5'd1, 5'd0, 17'd4);
        rom[2] = ri(OP_LW, 5'd2, 5'd0, 17'd4);
        do_reset();
        run(3);
        check("lw_r2", rf[2], 32'd7);

        clear_rom();
        rom[0] = ri(OP_ADDI, 5'd2, 5'd0, 17'd0);
        rom[1] = ri(OP_ADDI, 5'd3, 5'd0, 17'd0);
        rom[2] = ri(OP_ADDI, 5'd1, 5'd0, 17'd1);
        rom[3] = ri(OP_BNE, 5'd1, 5'd0, 17'd1);
        rom[4] = ri(OP_ADDI, 5'd2, 5'd0, 17'd9);
        rom[5] = ri(OP_ADDI, 5'd3, 5'd0, 17'd4);
        rom[6] = ri(OP_BLT, 5'd2, 5'd3, 17'd1);
        rom[7] = ri(OP_ADDI, 5'd5, 5'd0, 17'd1);
        rom[8] = ri(OP_ADDI, 5'd6, 5'd0, 17'd2);
        do_reset();
        run(5);
        check("bne_r2", rf[2], 32'd0);
        check("bne_r3", rf[3], 32'd4);
        run(2);
        check("blt_r5", rf[5], 32'd0);
        check("blt_r6", rf[6], 32'd2);

        clear_rom();
        rom[2] = jt(OP_JAL, 27'd5);
        rom[5] = ri(OP_JR, 5'd31, 5'd0, 17'd0);
        rom[3] = ri(OP_ADDI, 5'd9, 5'd0, 17'd1);
        do_reset();
        run(5);
        check("jal_r31", rf[31], 32'd3);
        check("jr_r9", rf[9], 32'd1);

        for (int i = 0; i < 4096; i++) rom[i] = rand_ins();
        do_reset();
        run(400);
        for (int i = 1; i < 32; i++) check($sformatf("rand_r%0d", i), rf[i], m_reg[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
